// File: rtl/reset_pkg.sv
// Shared types for the system reset sequencer: reset-cause codes and FSM states.
package reset_pkg;

  localparam logic [2:0] CAUSE_NONE = 3'd0;
  localparam logic [2:0] CAUSE_POR  = 3'd1;
  localparam logic [2:0] CAUSE_LOCK = 3'd2;
  localparam logic [2:0] CAUSE_BTN  = 3'd3;
  localparam logic [2:0] CAUSE_WDT  = 3'd4;
  localparam logic [2:0] CAUSE_SW   = 3'd5;

  typedef enum logic [2:0] {
    S_ASSERT,
    S_WAIT,
    S_DEBOUNCE,
    S_RELEASE,
    S_RUN
  } state_t;

endpackage

// File: rtl/reset_sequencer_sync_chain.sv
// Multi-flop synchroniser for one asynchronous bit into the clkout domain.
module sync_chain #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clkout,
  input  logic ext_reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clkout or negedge ext_reset) begin
    if (!ext_reset) ff <= {STAGES{RESET_VAL}};
    else            ff <= {ff[STAGES-2:0], d};
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// System reset controller: debounces button and PLL lock, releases domain resets
// in index order with a fixed stagger, and records the cause of the last reset.
module reset_sequencer #(
  parameter int N_DOMAINS       = 4,
  parameter int N_LOCK          = 2,
  parameter int DEBOUNCE_CYCLES = 65536,
  parameter int STAGGER_CYCLES  = 16,
  parameter int SYNC_STAGES     = 2
) (
  input  logic                 clkout,
  input  logic                 ext_reset,
  input  logic                 btn_n,
  input  logic [N_LOCK-1:0]    pll_lock,
  input  logic                 wdt_req,
  input  logic                 sw_req,
  input  logic                 cause_clr,
  output logic [N_DOMAINS-1:0] rst_n_out,
  output logic                 clk_hold,
  output logic                 busy,
  output logic [2:0]           cause,
  output logic [2:0]           state_dbg
);
  import reset_pkg::*;

  localparam int LAST_REL = (N_DOMAINS - 1) * STAGGER_CYCLES;
  localparam int CNT_MAX  = (DEBOUNCE_CYCLES > LAST_REL + 1) ? DEBOUNCE_CYCLES : LAST_REL + 1;
  localparam int CNT_W    = $clog2(CNT_MAX) + 1;
  localparam logic [CNT_W-1:0] DEB_LAST_C = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LAST_REL_C = CNT_W'(LAST_REL);

  logic              btn_s;
  logic [N_LOCK-1:0] lock_s;
  logic              lock_ok;

  sync_chain #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_btn (
    .clkout    (clkout),
    .ext_reset (ext_reset),
    .d         (btn_n),
    .q         (btn_s)
  );

  for (genvar i = 0; i < N_LOCK; i++) begin : g_lock_sync
    sync_chain #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_lock (
      .clkout    (clkout),
      .ext_reset (ext_reset),
      .d         (pll_lock[i]),
      .q         (lock_s[i])
    );
  end

  assign lock_ok = &lock_s;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [2:0]            cause_d, trig_cause;
  logic [N_DOMAINS-1:0]  rst_d;
  logic                  hold_d, busy_d;

  // Domain k is out of reset once the release counter has reached k*STAGGER_CYCLES.
  function automatic logic [N_DOMAINS-1:0] release_mask(input logic [CNT_W-1:0] c);
    logic [N_DOMAINS-1:0] m;
    m = '0;
    for (int k = 0; k < N_DOMAINS; k++)
      m[k] = (int'(c) >= k * STAGGER_CYCLES);
    return m;
  endfunction

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cause_d    = cause;
    trig_cause = CAUSE_NONE;
    rst_d      = '0;
    hold_d     = 1'b1;
    busy_d     = 1'b1;

    case (state_q)
      S_ASSERT: begin
        state_d = S_WAIT;
        cnt_d   = '0;
      end
      S_WAIT: begin
        if (lock_ok && btn_s) begin
          state_d = S_DEBOUNCE;
          cnt_d   = '0;
        end
      end
      S_DEBOUNCE: begin
        if (!lock_ok || !btn_s) begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end else if (cnt_q == DEB_LAST_C) begin
          state_d = (LAST_REL == 0) ? S_RUN : S_RELEASE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RELEASE: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_d == LAST_REL_C) state_d = S_RUN;
      end
      S_RUN: begin
        cnt_d = '0;
      end
      default: begin
        state_d = S_ASSERT;
        cnt_d   = '0;
      end
    endcase

    // Lock and button act once release has begun; wdt/sw only from RUN.
    if (state_q == S_RELEASE || state_q == S_RUN) begin
      if (!lock_ok)                          trig_cause = CAUSE_LOCK;
      else if (!btn_s)                       trig_cause = CAUSE_BTN;
      else if (state_q == S_RUN && wdt_req)  trig_cause = CAUSE_WDT;
      else if (state_q == S_RUN && sw_req)   trig_cause = CAUSE_SW;

      if (trig_cause != CAUSE_NONE) begin
        state_d = S_ASSERT;
        cnt_d   = '0;
        cause_d = trig_cause;
      end else if (state_q == S_RUN && cause_clr) begin
        cause_d = CAUSE_NONE;
      end
    end

    if (state_d == S_RELEASE) begin
      rst_d  = release_mask(cnt_d);
      hold_d = 1'b0;
    end else if (state_d == S_RUN) begin
      rst_d  = '1;
      hold_d = 1'b0;
      busy_d = 1'b0;
    end
  end

  always_ff @(posedge clkout or negedge ext_reset) begin
    if (!ext_reset) begin
      state_q   <= S_ASSERT;
      cnt_q     <= '0;
      cause     <= CAUSE_POR;
      rst_n_out <= '0;
      clk_hold  <= 1'b1;
      busy      <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cause     <= cause_d;
      rst_n_out <= rst_d;
      clk_hold  <= hold_d;
      busy      <= busy_d;
    end
  end

  assign state_dbg = state_q;

endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
Parametrised system reset controller in the clkout domain. Replaces the ad-hoc reset/debounce FSM and the single-domain reset counter at SoC top. Combines power-on reset, PLL lock(s), the debounced reset button, a watchdog request and a CPU software-reset request. Drives N staggered active-low domain resets, a CPU clock-hold, and a sticky reset-cause register.

Parameters:
N_DOMAINS, 4, number of reset outputs; released in index order 0..N-1
N_LOCK, 2, number of PLL lock inputs
DEBOUNCE_CYCLES, 65536, stable cycles required before release; must be >=1
STAGGER_CYCLES, 16, cycles between successive domain releases; 0 = all released together
SYNC_STAGES, 2, synchroniser depth on btn_n and pll_lock; must be >=2

Ports:
clkout  in  1  system clock
ext_reset  in  1  asynchronous active-low reset
btn_n  in  1  raw reset button, active-low, asynchronous
pll_lock  in  N_LOCK  raw PLL lock flags, asynchronous
wdt_req  in  1  watchdog reset request, synchronous level/pulse
sw_req  in  1  CPU software-reset request, synchronous pulse
cause_clr  in  1  clears cause register, synchronous pulse
rst_n_out  out  N_DOMAINS  per-domain active-low reset
clk_hold  out  1  1 = CPU clock must be held
busy  out  1  1 while not in RUN
cause  out  3  sticky last-reset cause

Behaviour:
- Async reset (ext_reset=0): rst_n_out=0, clk_hold=1, busy=1, cause=POR(1), state=ASSERT, counters=0. Synchroniser flops reset to 0, meaning "button pressed" and "unlocked".
- btn_n and each pll_lock bit pass through a SYNC_STAGES flop chain. All decisions use synced values. lock_ok = AND of synced locks.
- States:
  - ASSERT: all outputs asserted, count=0. Next cycle -> WAIT.
  - WAIT: go to DEBOUNCE when lock_ok=1 and synced btn_n=1.
  - DEBOUNCE: count increments each cycle.
    - If lock_ok=0 or btn_n=0: count=0, return to WAIT.
    - When count reaches DEBOUNCE_CYCLES-1: go to RELEASE, count=0.
  - RELEASE: rst_n_out[k] goes 1 on the edge where count = k*STAGGER_CYCLES. Bit 0 is set on the entry edge. clk_hold falls on the same edge as rst_n_out[0]. After the last domain is released -> RUN.
  - RUN: busy=0. Triggers return the FSM to ASSERT.
- Triggers and priority (highest first):
  - lock loss -> cause LOCK(2)
  - btn press -> cause BTN(3)
  - wdt_req -> cause WDT(4)
  - sw_req -> cause SW(5)
- Trigger effect: on the next edge all rst_n_out=0, clk_hold=1, busy=1, and cause is loaded.
- Trigger scope:
  - lock loss and button are honoured in RELEASE and RUN.
  - wdt_req and sw_req are honoured only in RUN; elsewhere they are ignored.
- Latency: raw btn_n falling edge to rst_n_out=0 is SYNC_STAGES+1 cycles. sw_req/wdt_req to reset is 1 cycle.
- cause: codes 0 NONE, 1 POR, 2 LOCK, 3 BTN, 4 WDT, 5 SW.
  - cause_clr sets cause to NONE only in RUN.
  - If cause_clr and a trigger occur in the same cycle, the trigger wins.
  - Retained across all non-POR resets.
- Counter width is $clog2(max(DEBOUNCE_CYCLES, (N_DOMAINS-1)*STAGGER_CYCLES+1)) + 1. No wrap is possible within a state.
- A button held continuously keeps the FSM in WAIT indefinitely; there is no auto-repeat.
- All outputs are registered and glitch-free. rst_n_out never deasserts out of index order.

Decomposition:
- Package reset_pkg:
  - cause codes (CAUSE_NONE..CAUSE_SW, 3-bit)
  - state enum (ASSERT, WAIT, DEBOUNCE, RELEASE, RUN)
- One sub-module: sync_chain, with parameters STAGES and RESET_VAL, async active-low reset. Instantiated once for btn_n and once per lock bit.
- The FSM, counter and cause register stay in reset_sequencer.

Test Plan:
All cases use N_DOMAINS=3, DEBOUNCE_CYCLES=8, STAGGER_CYCLES=4, SYNC_STAGES=2.
1. POR, locks=2'b11, btn_n=1 -> outputs and release order:
   - rst_n_out[0] and clk_hold flip 8 cycles after entering DEBOUNCE.
   - rst_n_out[1] follows 4 cycles later, rst_n_out[2] at +8 cycles.
   - busy falls with rst_n_out[2]; cause=1.
2. Lock bit 1 drops for 1 cycle at debounce count 5 -> timing restarts:
   - Return to WAIT, then a full 8-cycle debounce restarts.
   - Release is delayed by exactly the restart; no domain releases early.
3. In RUN, btn_n low for 3 cycles -> reset asserted:
   - rst_n_out=3'b000 on cycle 3 after the falling edge; cause=3.
   - Full re-sequence once the button is released.
4. In RUN, sw_req and wdt_req in the same cycle -> cause=4 (WDT), reset on next edge. Then cause_clr in RUN -> cause=0.
5. In RELEASE, after domain 0 is released, lock 0 drops:
   - All domains re-asserted within SYNC_STAGES+1 cycles; cause=2.
   - sw_req pulsed during RELEASE has no effect.
6. ext_reset asserted mid-RUN -> immediate async clear: rst_n_out=0, clk_hold=1, cause=1.
